// File: rtl/rate_counter_gen.sv
// Programmable-rate up/down counter: a shared prescaler with four run-time selectable divide ratios
// drives a modulo-(MAX_COUNT+1) counter. Define RATE_COUNTER_SAT_EN to make the counter saturate instead of wrap.
module rate_counter_gen #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int DIV_W     = 28,
  parameter int DIV0      = 1,
  parameter int DIV1      = 50000000,
  parameter int DIV2      = 100000000,
  parameter int DIV3      = 200000000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       rate_sel,
  input  logic             run,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic             wrap,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);
  localparam bit               FULL_RANGE = (MAX_COUNT == (1 << WIDTH) - 1);
  localparam logic [DIV_W-1:0] RELOAD0    = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] RELOAD1    = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] RELOAD2    = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] RELOAD3    = DIV_W'(DIV3 - 1);

  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] pre_nxt;
  logic [DIV_W-1:0] reload;
  logic [1:0]       sel_q;
  logic             sel_chg;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Reload always follows the live selection: on a change it starts the new period at once.
  always_comb begin
    unique case (rate_sel)
      2'd0:    reload = RELOAD0;
      2'd1:    reload = RELOAD1;
      2'd2:    reload = RELOAD2;
      default: reload = RELOAD3;
    endcase
  end

  assign sel_chg = (rate_sel != sel_q);
  assign tick    = run & ~sel_chg & (pre == '0);

  // A full-range counter can never receive an out-of-range load value.
  generate
    if (FULL_RANGE) begin : g_no_clamp
      assign load_clamped = load_val;
    end else begin : g_clamp
      assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end
  endgenerate

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    pre_nxt = pre;
    if (sel_chg)         pre_nxt = reload;
    else if (!run)       pre_nxt = pre;
    else if (pre == '0)  pre_nxt = reload;
    else                 pre_nxt = pre - 1'b1;
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = load_clamped;
    end else if (tick && up) begin
      if (count == MAX_VAL) begin
`ifdef RATE_COUNTER_SAT_EN
        count_nxt = MAX_VAL;
`else
        count_nxt = '0;
        wrap_nxt  = 1'b1;
`endif
      end else begin
        count_nxt = count + 1'b1;
      end
    end else if (tick && !up) begin
      if (count == '0) begin
`ifdef RATE_COUNTER_SAT_EN
        count_nxt = '0;
`else
        count_nxt = MAX_VAL;
        wrap_nxt  = 1'b1;
`endif
      end else begin
        count_nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      pre   <= '0;
      sel_q <= 2'd0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      pre   <= pre_nxt;
      sel_q <= rate_sel;
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_rate_counter_gen.sv
// Directed bench for rate_counter_gen with small divide ratios (1/4/8/16) and MAX_COUNT=9.
// Inputs change on the falling edge; outputs are compared 1 ns later, before the next rising edge.
module tb_rate_counter_gen;

`ifdef RATE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       clear;
  logic [1:0] rate_sel;
  logic       run;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       tick;
  logic       wrap;
  logic [3:0] count;

  rate_counter_gen #(
    .WIDTH(4), .MAX_COUNT(9), .DIV_W(28),
    .DIV0(1), .DIV1(4), .DIV2(8), .DIV3(16)
  ) dut (
    .clk(clk), .clear(clear), .rate_sel(rate_sel), .run(run), .up(up),
    .load(load), .load_val(load_val), .tick(tick), .wrap(wrap), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clear;
    logic [1:0] rs;
    logic       run;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic       exp_tick;
    logic       tick_chk;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   vi = 0;
  int   passed = 0;
  int   total = 0;

  function automatic vec_t mk(logic c, logic [1:0] rs, logic r, logic u, logic l, logic [3:0] lv,
                              logic et, logic tc, logic [3:0] ec, logic ew);
    vec_t v;
    v.clear = c; v.rs = rs; v.run = r; v.up = u; v.load = l; v.lv = lv;
    v.exp_tick = et; v.tick_chk = tc; v.exp_count = ec; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    clear = v.clear; rate_sel = v.rs; run = v.run; up = v.up; load = v.load; load_val = v.lv;
    #1;
    if (v.tick_chk) check({name, ".tick"}, {31'd0, tick}, {31'd0, v.exp_tick});
    check({name, ".count"}, {28'd0, count}, {28'd0, v.exp_count});
    check({name, ".wrap"}, {31'd0, wrap}, {31'd0, v.exp_wrap});
  endtask

  task automatic run_vecs(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(vecs[vi], $sformatf("%s[%0d]", tag, k));
      vi++;
    end
  endtask

  // Hand-sequence helper: normal operation (no clear, no load), tick always checked.
  task automatic seq(input logic [1:0] rs, input logic r, input logic u, input logic et,
                     input logic [3:0] ec, input logic ew, input string name);
    step(mk(1'b0, rs, r, u, 1'b0, 4'd0, et, 1'b1, ec, ew), name);
  endtask

  initial begin
    clear = 1'b1; rate_sel = 2'd0; run = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;

    // Reset and first period at DIV1=4: reload in the select-change cycle, tick 4 cycles later.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    // Divide-by-1 counting down through 0->9, then loads (clamp, tick dropped, no wrap from load).
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 9, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 8, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 5, 1, 1, 7, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 12, 1, 1, 5, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 1, 9, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 0));
    // Clear in a tick cycle at count 7, then saturate/wrap behaviour at both ends.
    vecs.push_back(mk(0, 0, 1, 1, 1, 7, 0, 1, 5, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 8, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 8, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 9, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, SAT ? 4'd9 : 4'd0, SAT ? 1'b0 : 1'b1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, SAT ? 4'd9 : 4'd1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, SAT ? 4'd8 : 4'd0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, SAT ? 4'd0 : 4'd9, SAT ? 1'b0 : 1'b1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, SAT ? 4'd0 : 4'd8, 0));

    run_vecs(6, "t1_start");

    // Ten full periods of 4: count 1..9,0,1 and a single wrap pulse after 9->0.
    for (int i = 1; i <= 10; i++) begin
      for (int j = 0; j < 3; j++)
        seq(2'd1, 1, 1, 0, 4'(i % 10), (i == 10 && j == 0), $sformatf("t1_idle_%0d_%0d", i, j));
      seq(2'd1, 1, 1, 1, 4'(i % 10), 0, $sformatf("t1_tick_%0d", i));
    end

    run_vecs(9, "t2_t3");

    // Ratio switch 3 -> 1 mid-period, then pause, then a switch exactly on a tick cycle.
    seq(2'd3, 1, 1, 0, 2, 0, "t4_sel3");
    for (int i = 0; i < 4; i++) seq(2'd3, 1, 1, 0, 2, 0, $sformatf("t4_run3_%0d", i));
    seq(2'd1, 1, 1, 0, 2, 0, "t4_switch");
    for (int i = 0; i < 3; i++) seq(2'd1, 1, 1, 0, 2, 0, $sformatf("t4_wait_%0d", i));
    seq(2'd1, 1, 1, 1, 2, 0, "t4_tick");
    for (int i = 0; i < 10; i++) seq(2'd1, 0, 1, 0, 3, 0, $sformatf("t4_pause_%0d", i));
    for (int i = 0; i < 3; i++) seq(2'd1, 1, 1, 0, 3, 0, $sformatf("t4_resume_%0d", i));
    seq(2'd1, 1, 1, 1, 3, 0, "t4_resume_tick");
    for (int i = 0; i < 3; i++) seq(2'd1, 1, 1, 0, 4, 0, $sformatf("t4_pre_%0d", i));
    seq(2'd2, 1, 1, 0, 4, 0, "t4_switch_on_tick");
    for (int i = 0; i < 7; i++) seq(2'd2, 1, 1, 0, 4, 0, $sformatf("t4_div8_%0d", i));
    seq(2'd2, 1, 1, 1, 4, 0, "t4_div8_tick");

    run_vecs(13, "t5_t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rate_counter_gen.md
Name: rate_counter_gen

Overview:
- Parametrised successor to the fixed four-rate flash counter.
- Contains one shared programmable prescaler; four per-instance divide ratios selected at run time.
- Drives a WIDTH-bit modulo-(MAX_COUNT+1) up/down counter with parallel load, run/pause, and tick and wrap strobes.
- Sits between board switches/clock and the hex display decoders; one instance per displayed digit chain.

Parameters:
- WIDTH, 4: counter width in bits.
- MAX_COUNT, 15: highest count value; count wraps MAX_COUNT<->0. Must be < 2^WIDTH.
- DIV_W, 28: prescaler width in bits.
- DIV0, 1: clk cycles per tick when rate_sel=0. Must be >= 1 and < 2^DIV_W.
- DIV1, 50000000: clk cycles per tick when rate_sel=1 (1 Hz at 50 MHz).
- DIV2, 100000000: clk cycles per tick when rate_sel=2.
- DIV3, 200000000: clk cycles per tick when rate_sel=3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clear  in  1  reset; synchronous, active-high.
- rate_sel  in  2  selects DIV0..DIV3.
- run  in  1  1 = prescaler advances; 0 = prescaler and counter frozen (load still honoured).
- up  in  1  1 = count up, 0 = count down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- tick  out  1  combinational; high in the cycle the counter advances at the next edge.
- wrap  out  1  registered one-cycle pulse after a wrap.
- count  out  WIDTH  current count.

Behaviour:
- Internal state: pre (DIV_W bits), sel_q (2 bits, registered copy of rate_sel), count, wrap.
- Reset (clear=1 at an edge): pre=0, sel_q=0, count=0, wrap=0. clear overrides every other input. A mid-operation clear discards any pending tick.
- sel_chg = (rate_sel != sel_q). sel_q <= rate_sel every non-reset edge.
- tick = run & ~sel_chg & (pre==0).
- Prescaler, per non-reset edge, in priority order:
  - sel_chg: pre <= DIVsel-1. The period restarts with the new ratio and no tick occurs that cycle. This also applies while run=0.
  - else if run=0: pre holds.
  - else if pre==0: pre <= DIVsel-1.
  - else: pre <= pre-1.
- Resulting tick timing:
  - Ticks every DIVsel cycles while run=1.
  - DIVsel=1 gives a tick every cycle.
  - First tick comes in the first cycle after reset release, provided rate_sel==0; otherwise DIVsel cycles after the reload.
- Counter, per non-reset edge, in priority order:
  - load: count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val. A coincident tick is dropped. Prescaler is unaffected.
  - else if tick & up: count <= (count==MAX_COUNT) ? 0 : count+1.
  - else if tick & ~up: count <= (count==0) ? MAX_COUNT : count-1.
  - else: hold.
- wrap <= 1 only on an edge where a tick moved count MAX_COUNT->0 (up) or 0->MAX_COUNT (down); else 0. Load never raises wrap.
- Arithmetic is unsigned, WIDTH bits. Comparisons are against the parameter, never 2^WIDTH-1, unless MAX_COUNT equals it.
- Changing up mid-period takes effect at the next tick; no prescaler restart.

Optional Feature:
- Macro: RATE_COUNTER_SAT_EN.
- Defined: counter saturates instead of wrapping. Up at MAX_COUNT holds MAX_COUNT; down at 0 holds 0. wrap stays 0 permanently. tick is still generated.
- Undefined: modulo wrap behaviour as above.

Test Plan:
- Bench overrides: DIV0=1, DIV1=4, DIV2=8, DIV3=16, WIDTH=4, MAX_COUNT=9.
- Test 1: clear 2 cycles, then rate_sel=1, run=1, up=1 -> first tick 4 cycles after the reload cycle, then every 4 cycles; count 0,1..9,0; wrap high exactly 1 cycle after 9->0.
- Test 2: rate_sel=0, up=0, count=0 -> tick every cycle; count 0->9->8; wrap pulses once after 0->9.
- Test 3: load=1 with load_val=5 in a tick cycle -> count=5, not 6; load_val=12 -> count=9; wrap=0.
- Test 4: rate_sel=3, run for 5 cycles, switch to rate_sel=1 -> no tick in the switch cycle; next tick exactly 4 cycles later; run=0 for 10 cycles -> count and pre frozen, tick=0.
- Test 5: clear=1 asserted in a tick cycle with count=7 -> next cycle count=0, wrap=0, pre=0; no increment observed.
- Test 6: with RATE_COUNTER_SAT_EN, rate_sel=0, up=1 from 8 -> 9, 9, 9; wrap never 1; then up=0 down to 0 -> holds 0.
